// File: rtl/spi_frame_slave_pkg.sv
// Shared definitions for the SPI frame responder.
//  - frame size and the bit counter width derived from it
//  - header RnW bit values
//  - FSM state encoding (3-bit)
//  - byte_swap: the wire carries the low byte first, so a 16-bit shift
//    register holds {low,high} and must be swapped to get the bus word
//    (and swapped again before a bus word is shifted out)
package spi_frame_slave_pkg;

   localparam int FRAME_BITS = 16;
   localparam int CNT_W      = $clog2(FRAME_BITS);

   localparam logic RNW_READ  = 1'b1;
   localparam logic RNW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HEADER = 3'd1,
      ST_WDATA  = 3'd2,
      ST_RREQ   = 3'd3,
      ST_RWAIT  = 3'd4,
      ST_RDATA  = 3'd5
   } state_t;

   function automatic logic [FRAME_BITS-1:0] byte_swap(input logic [FRAME_BITS-1:0] w);
      return {w[7:0], w[15:8]};
   endfunction

endpackage

// File: rtl/spi_frame_slave_edge_sync.sv
// Synchronizer and edge detector for the SPI pins.
// Ports:
//  clk, resetn          system clock, async active-low reset
//  sck, ss, mosi        raw SPI pins
//  sck_rise, sck_fall   1-clk pulses on synchronized sck edges
//  ss_rise, ss_fall     1-clk pulses on synchronized ss edges
//  mosi_s               mosi delayed by the same number of stages as sck,
//                       so it is the bit that was on the wire at the sck rise
// Reset values: sck chain resets high (its idle level) so releasing reset
// never fakes a rise. ss chain resets low so that releasing reset in the
// middle of a frame (ss still low) does not produce an ss fall; the slave
// then waits for a genuine ss fall to start decoding.
module spi_frame_slave_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic sck,
   input  logic ss,
   input  logic mosi,
   output logic sck_rise,
   output logic sck_fall,
   output logic ss_rise,
   output logic ss_fall,
   output logic mosi_s
);

   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_prev_q, sck_prev_d;
   logic                   ss_prev_q, ss_prev_d;
   logic                   sck_s, ss_s;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign ss_s   = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   always_comb begin
      sck_sync_d  = (sck_sync_q << 1)  | SYNC_STAGES'(sck);
      ss_sync_d   = (ss_sync_q << 1)   | SYNC_STAGES'(ss);
      mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
      sck_prev_d  = sck_s;
      ss_prev_d   = ss_s;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sck_sync_q  <= '1;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b1;
         ss_prev_q   <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         ss_sync_q   <= ss_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_prev_q  <= sck_prev_d;
         ss_prev_q   <= ss_prev_d;
      end
   end

   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign ss_rise  = ss_s & ~ss_prev_q;
   assign ss_fall  = ~ss_s & ss_prev_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI frame responder: decodes host frames into single-cycle bus strobes.
// Frame = header {addr[14:0],RnW} + data words, all within one ss-low window.
// Wire order: low byte first, MSB first within each byte (sck idles high,
// host samples/drives on rise/fall respectively).
// Ports:
//  clk, resetn        system clock, async active-low reset
//  sck, ss, mosi      SPI inputs (asynchronous to clk)
//  miso, miso_oe      SPI output and its enable
//  addr, wr_data, we  write bus (we is 1 clk, addr/wr_data stable during it)
//  re, rd_data        read bus (rd_data valid RD_LATENCY clks after re)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ss high, waiting for ss fall
// ST_HEADER | shifting in the header word
// ST_WDATA  | write burst: each completed word strobes we, then addr+1
// ST_RREQ   | issue re for the current addr
// ST_RWAIT  | wait RD_LATENCY clks, then load tx and present its MSB
// ST_RDATA  | shift tx out on sck falls; word end -> addr+1, fetch again
module spi_frame_slave
   import spi_frame_slave_pkg::*;
#(
   parameter int ADDR_WIDTH  = 15,
   parameter int DATA_WIDTH  = 16,
   parameter int RD_LATENCY  = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  sck,
   input  logic                  ss,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  we,
   output logic                  re,
   input  logic [DATA_WIDTH-1:0] rd_data
);

   localparam int                LAT_W   = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FRAME_BITS - 1);

   logic sck_rise, sck_fall, ss_rise, ss_fall, mosi_s;

   spi_frame_slave_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk      (clk),
      .resetn   (resetn),
      .sck      (sck),
      .ss       (ss),
      .mosi     (mosi),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .ss_rise  (ss_rise),
      .ss_fall  (ss_fall),
      .mosi_s   (mosi_s)
   );

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  we_q, we_d;
   logic                  re_q, re_d;
   logic                  miso_q, miso_d;
   logic                  miso_oe_q, miso_oe_d;
   logic [LAT_W-1:0]      lat_q, lat_d;

   logic [DATA_WIDTH-1:0] rx_next;
   logic [DATA_WIDTH-1:0] word;
   logic                  word_done;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      miso_d    = miso_q;
      miso_oe_d = miso_oe_q;
      lat_d     = lat_q;
      rx_next   = {rx_q[DATA_WIDTH-2:0], mosi_s};
      word      = byte_swap(rx_next);
      word_done = 1'b0;

      // Address advances the clk after the write strobe, so it is stable
      // for the whole we pulse.
      if (we_q) begin
         addr_d = addr_q + 1'b1;
      end

      // Bits are counted in every active state, including reads where the
      // incoming data is ignored, so word boundaries stay aligned.
      if ((state_q != ST_IDLE) && sck_rise) begin
         rx_d      = rx_next;
         cnt_d     = cnt_q + 1'b1;
         word_done = (cnt_q == CNT_MAX);
      end

      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               cnt_d     = '0;
               rx_d      = '0;
               tx_d      = '0;
               miso_oe_d = 1'b1;
               state_d   = ST_HEADER;
            end
         end
         ST_HEADER: begin
            if (word_done) begin
               addr_d  = word[ADDR_WIDTH:1];
               state_d = (word[0] == RNW_WRITE) ? ST_WDATA : ST_RREQ;
            end
         end
         ST_WDATA: begin
            if (word_done) begin
               wr_data_d = word;
               we_d      = 1'b1;
            end
         end
         ST_RREQ: begin
            re_d    = 1'b1;
            lat_d   = LAT_W'(RD_LATENCY);
            state_d = ST_RWAIT;
         end
         ST_RWAIT: begin
            if (lat_q == '0) begin
               tx_d    = byte_swap(rd_data);
               miso_d  = rd_data[7];
               state_d = ST_RDATA;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         ST_RDATA: begin
            // The fall right after a word boundary (cnt==0) keeps the freshly
            // loaded MSB on miso; every later fall advances one bit.
            if (sck_fall && (cnt_q != '0)) begin
               tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
               miso_d = tx_q[DATA_WIDTH-2];
            end
            if (word_done) begin
               addr_d  = addr_q + 1'b1;
               state_d = ST_RREQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Frame end overrides everything except a write that completed on
      // this very clk, which is still strobed.
      if ((state_q != ST_IDLE) && ss_rise) begin
         state_d   = ST_IDLE;
         re_d      = 1'b0;
         miso_oe_d = 1'b0;
      end

      if ((state_d != ST_RWAIT) && (state_d != ST_RDATA)) begin
         miso_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         addr_q    <= '0;
         wr_data_q <= '0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         miso_q    <= 1'b0;
         miso_oe_q <= 1'b0;
         lat_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rx_q      <= rx_d;
         tx_q      <= tx_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         we_q      <= we_d;
         re_q      <= re_d;
         miso_q    <= miso_d;
         miso_oe_q <= miso_oe_d;
         lat_q     <= lat_d;
      end
   end

   assign miso    = miso_q;
   assign miso_oe = miso_oe_q;
   assign addr    = addr_q;
   assign wr_data = wr_data_q;
   assign we      = we_q;
   assign re      = re_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: a host SPI model drives frames, a bus model
// answers reads, and a scoreboard checks we/re/miso against expectations
// queued when each frame is driven.
module tb_spi_frame_slave;

   localparam int HALF = 8;   // clk cycles per sck half period

   logic        clk = 1'b0;
   logic        resetn;
   logic        sck, ss, mosi;
   logic        miso, miso_oe, we, re;
   logic [14:0] addr;
   logic [15:0] wr_data;
   logic [15:0] rd_data = '0;

   int n_vec = 0;
   int n_err = 0;

   logic [30:0] exp_wr_q[$];   // {addr, data}
   logic [14:0] exp_re_q[$];
   logic [15:0] exp_rx_q[$];
   logic [15:0] wdata_q[$];

   logic [15:0] sine_tbl [17] = '{
      16'h0000, 16'h30FB, 16'h5A82, 16'h7641, 16'h7FFF, 16'h7641, 16'h5A82, 16'h30FB,
      16'h0000, 16'hCF05, 16'hA57E, 16'h89BF, 16'h8001, 16'h89BF, 16'hA57E, 16'hCF05,
      16'h0000};

   spi_frame_slave dut (
      .clk     (clk),
      .resetn  (resetn),
      .sck     (sck),
      .ss      (ss),
      .mosi    (mosi),
      .miso    (miso),
      .miso_oe (miso_oe),
      .addr    (addr),
      .wr_data (wr_data),
      .we      (we),
      .re      (re),
      .rd_data (rd_data)
   );

   always #10 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] bus_val(input logic [14:0] a);
      if (a == 15'h7001) return 16'h1234;
      return {a[7:0] ^ 8'h5A, a[14:8] ^ 7'h33, 1'b1};
   endfunction

   // Bus slave, RD_LATENCY = 1
   always @(posedge clk) begin
      if (re) rd_data <= bus_val(addr);
   end

   // Scoreboard side: compare strobes as the DUT produces them
   always @(negedge clk) begin
      if (resetn) begin
         if (we || re) chk("we_re_excl", {31'b0, we & re}, 32'h0);
         if (we) begin
            if (exp_wr_q.size() == 0) chk("we_extra", {1'b0, addr, wr_data}, 32'hFFFF_FFFF);
            else                      chk("we_addr_data", {1'b0, addr, wr_data}, {1'b0, exp_wr_q.pop_front()});
         end
         if (re) begin
            if (exp_re_q.size() == 0) chk("re_extra", {17'b0, addr}, 32'hFFFF_FFFF);
            else                      chk("re_addr", {17'b0, addr}, {17'b0, exp_re_q.pop_front()});
         end
      end
   end

   task automatic spi_bit(input logic b, input bit ss_after, output logic m);
      sck  = 1'b0;
      mosi = b;
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      m   = miso;
      if (ss_after) ss = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic xfer_word(input logic [15:0] w, input bit end_ss, output logic [15:0] got);
      logic [15:0] wire_w;
      logic [15:0] rxw;
      logic        m;
      wire_w = {w[7:0], w[15:8]};
      rxw    = '0;
      for (int i = 15; i >= 0; i--) begin
         spi_bit(wire_w[i], end_ss && (i == 0), m);
         rxw[i] = m;
      end
      got = {rxw[7:0], rxw[15:8]};
   endtask

   task automatic begin_frame();
      ss = 1'b0;
      repeat (HALF) @(negedge clk);
      chk("miso_oe_active", {31'b0, miso_oe}, 32'h1);
   endtask

   task automatic end_frame();
      ss = 1'b1;
      repeat (4 * HALF) @(negedge clk);
      chk("idle_oe_miso", {30'b0, miso_oe, miso}, 32'h0);
   endtask

   task automatic write_burst(input logic [14:0] a, input int n, input bit ss_on_last);
      logic [15:0] d, dummy;
      logic [14:0] ad;
      ad = a;
      begin_frame();
      xfer_word({a, 1'b0}, 1'b0, dummy);
      for (int k = 0; k < n; k++) begin
         d = wdata_q.pop_front();
         exp_wr_q.push_back({ad, d});
         ad = ad + 15'd1;
         xfer_word(d, ss_on_last && (k == n - 1), dummy);
      end
      end_frame();
   endtask

   // ss rises with the last sck rise, so no prefetch follows the final word
   task automatic read_burst(input logic [14:0] a, input int n);
      logic [15:0] got;
      logic [14:0] ad;
      ad = a;
      begin_frame();
      exp_re_q.push_back(ad);
      xfer_word({a, 1'b1}, 1'b0, got);
      for (int k = 0; k < n; k++) begin
         exp_rx_q.push_back(bus_val(ad));
         if (k < n - 1) exp_re_q.push_back(ad + 15'd1);
         xfer_word(16'hFFFF, k == n - 1, got);
         chk("miso_word", {16'b0, got}, {16'b0, exp_rx_q.pop_front()});
         ad = ad + 15'd1;
      end
      end_frame();
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {1'b0, addr, wr_data}, 32'h0);
      chk(tag, {28'b0, we, re, miso, miso_oe}, 32'h0);
   endtask

   initial begin
      logic m;
      logic [15:0] dummy;
      resetn = 1'b0;
      ss     = 1'b1;
      sck    = 1'b1;
      mosi   = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset_state");
      resetn = 1'b1;
      repeat (6) @(negedge clk);

      // single write
      wdata_q.push_back(16'h0001);
      write_burst(15'h7001, 1, 1'b0);

      // single read
      read_burst(15'h7001, 1);

      // 17-word burst write
      for (int i = 0; i < 17; i++) wdata_q.push_back(sine_tbl[i]);
      write_burst(15'h6000, 17, 1'b0);

      // abort after 9 data bits: nothing expected
      begin_frame();
      xfer_word({15'h0300, 1'b0}, 1'b0, dummy);
      for (int i = 0; i < 9; i++) spi_bit(1'b1, 1'b0, m);
      end_frame();

      // next frame decodes normally; ss rises on the last bit's clk
      wdata_q.push_back(16'hA55A);
      write_burst(15'h0300, 1, 1'b1);

      // address wrap on write
      wdata_q.push_back(16'h1111);
      wdata_q.push_back(16'h2222);
      write_burst(15'h7FFF, 2, 1'b0);

      // multi-word read across the wrap
      read_burst(15'h7FFE, 3);

      // reset in the middle of a read
      begin_frame();
      exp_re_q.push_back(15'h0200);
      xfer_word({15'h0200, 1'b1}, 1'b0, dummy);
      for (int i = 0; i < 5; i++) spi_bit(1'b0, 1'b0, m);
      resetn = 1'b0;
      #1;
      chk_all_zero("reset_mid_read");
      sck = 1'b1;
      repeat (4) @(negedge clk);
      resetn = 1'b1;
      repeat (6) @(negedge clk);

      // ss still low after reset: no fresh fall, so this frame is ignored
      xfer_word({15'h0400, 1'b0}, 1'b0, dummy);
      chk("no_oe_without_ss_fall", {31'b0, miso_oe}, 32'h0);
      xfer_word(16'hCAFE, 1'b0, dummy);
      ss = 1'b1;
      repeat (4 * HALF) @(negedge clk);

      // post-reset write
      wdata_q.push_back(16'hBEEF);
      write_burst(15'h1000, 1, 1'b0);

      repeat (10) @(negedge clk);
      chk("wr_drained", exp_wr_q.size(), 32'h0);
      chk("re_drained", exp_re_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
